// File: rtl/swap_reg_file.sv
// rtl/swap_reg_file.sv - register file with two read ports, one write port and
// a compare-and-swap engine that orders adjacent entries (lo <= hi).
module swap_reg_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int SIGNED = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             cas_start,
  input  logic [AW-1:0]    cas_addr,
  output logic             cas_busy,
  output logic             cas_done,
  output logic             cas_swapped,
  output logic             cas_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;
  logic [AW-1:0]    addr_hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             gt;

  assign addr_hi   = addr + AW'(1);
  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign gt        = (SIGNED != 0) ? ($signed(lo) > $signed(hi)) : (lo > hi);

  // Array and controller share one block so external writes can be gated by state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state       <= S_IDLE;
      addr        <= '0;
      lo          <= '0;
      hi          <= '0;
      cas_busy    <= 1'b0;
      cas_done    <= 1'b0;
      cas_swapped <= 1'b0;
      cas_err     <= 1'b0;
    end else begin
      cas_done    <= 1'b0;
      cas_swapped <= 1'b0;
      cas_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) mem[wr_addr] <= wr_data;
          if (cas_start) begin
            if (cas_addr == AW'(DEPTH - 1)) begin
              cas_err <= 1'b1;
            end else begin
              addr     <= cas_addr;
              state    <= S_READ;
              cas_busy <= 1'b1;
            end
          end
        end
        S_READ: begin
          lo    <= mem[addr];
          hi    <= mem[addr_hi];
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (gt) begin
            mem[addr]    <= hi;
            mem[addr_hi] <= lo;
          end
          cas_swapped <= gt;
          cas_done    <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          cas_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_reg_file.sv
// tb/tb_swap_reg_file.sv - scoreboard bench for swap_reg_file (unsigned and
// signed instances driven with the same stimulus).
module tb_swap_reg_file;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        cas_start;
  logic [2:0]  cas_addr;

  logic [31:0] rd_data_a, rd_data_b, rd_data_a_s, rd_data_b_s;
  logic        cas_busy, cas_done, cas_swapped, cas_err;
  logic        cas_busy_s, cas_done_s, cas_swapped_s, cas_err_s;

  typedef struct {
    logic        sw;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          s_done_cnt = 0;
  logic        s_last_sw = 1'b0;
  bit          final_pass = 1'b0;

  always #5 clock = ~clock;

  swap_reg_file #(.WIDTH(32), .DEPTH(8), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .cas_start(cas_start), .cas_addr(cas_addr), .cas_busy(cas_busy), .cas_done(cas_done),
    .cas_swapped(cas_swapped), .cas_err(cas_err)
  );

  swap_reg_file #(.WIDTH(32), .DEPTH(8), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_s), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_s),
    .cas_start(cas_start), .cas_addr(cas_addr), .cas_busy(cas_busy_s), .cas_done(cas_done_s),
    .cas_swapped(cas_swapped_s), .cas_err(cas_err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    model[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Issues one compare-and-swap and checks the busy/done timeline; the
  // scoreboard monitor compares swapped flag and read-port data at done.
  task automatic do_cas(input int a, input bit same_wr, input logic [31:0] same_data,
                        input bit interfere);
    exp_t        e;
    logic [31:0] lo, hi;
    rd_addr_a = 3'(a);
    rd_addr_b = 3'(a + 1);
    if (same_wr) begin
      wr_en    = 1'b1;
      wr_addr  = 3'(a);
      wr_data  = same_data;
      model[a] = same_data;
    end
    lo   = model[a];
    hi   = model[a+1];
    e.sw = (lo > hi);
    if (e.sw) begin
      model[a]   = hi;
      model[a+1] = lo;
    end
    e.a = model[a];
    e.b = model[a+1];
    exp_q.push_back(e);
    cas_start = 1'b1;
    cas_addr  = 3'(a);
    tick();
    cas_start = 1'b0;
    wr_en     = 1'b0;
    check("busy_n1", 32'(cas_busy), 1);
    check("done_n1", 32'(cas_done), 0);
    if (interfere) begin
      wr_en   = 1'b1;
      wr_addr = 3'd2;
      wr_data = 32'h55;
    end
    tick();
    wr_en = 1'b0;
    check("busy_n2", 32'(cas_busy), 1);
    check("done_n2", 32'(cas_done), 0);
    tick();
    check("busy_n3", 32'(cas_busy), 1);
    check("done_n3", 32'(cas_done), 1);
    if (interfere) begin
      cas_start = 1'b1;
      cas_addr  = 3'd0;
    end
    tick();
    cas_start = 1'b0;
    check("busy_n4", 32'(cas_busy), 0);
    check("done_n4", 32'(cas_done), 0);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (cas_done_s) begin
        s_done_cnt++;
        s_last_sw = cas_swapped_s;
      end
      if (cas_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(cas_done), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_swapped", 32'(cas_swapped), 32'(e.sw));
          check("sb_rd_a", rd_data_a, e.a);
          check("sb_rd_b", rd_data_b, e.b);
          if (final_pass) check("final_noswap", 32'(cas_swapped), 0);
        end
      end else begin
        check("swapped_idle", 32'(cas_swapped), 0);
      end
    end
  end

  initial begin
    int cnt0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = 3'd1; cas_start = 1'b0; cas_addr = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_busy", 32'(cas_busy), 0);
    check("rst_done", 32'(cas_done), 0);
    check("rst_swapped", 32'(cas_swapped), 0);
    check("rst_err", 32'(cas_err), 0);
    check("rst_rd_a", rd_data_a, 0);
    check("rst_rd_b", rd_data_b, 0);

    // Signed vs unsigned ordering of 0xFFFFFFFF and 1.
    do_write(0, 32'hFFFF_FFFF);
    do_write(1, 32'd1);
    cnt0 = s_done_cnt;
    do_cas(0, 1'b0, 0, 1'b0);
    check("s_done_cnt", 32'(s_done_cnt - cnt0), 1);
    check("s_swapped", 32'(s_last_sw), 0);
    check("s_rd_a", rd_data_a_s, 32'hFFFF_FFFF);
    check("s_rd_b", rd_data_b_s, 32'd1);

    // Basic swap, then interference during busy and done.
    do_write(2, 32'd9);
    do_write(3, 32'd4);
    do_cas(2, 1'b0, 0, 1'b0);
    do_write(2, 32'd9);
    do_write(3, 32'd4);
    do_cas(2, 1'b0, 0, 1'b1);
    check("intf_e2", rd_data_a, 32'd4);

    // Equal operands never swap; write in the same edge as the request.
    do_write(6, 32'd7);
    do_cas(5, 1'b0, 0, 1'b0);
    do_write(5, 32'd7);
    do_cas(5, 1'b0, 0, 1'b0);
    do_write(5, 32'd50);
    do_cas(4, 1'b1, 32'd100, 1'b0);

    // Request at the last index is rejected.
    rd_addr_a = 3'd7;
    cas_start = 1'b1;
    cas_addr  = 3'd7;
    tick();
    cas_start = 1'b0;
    check("err_pulse", 32'(cas_err), 1);
    check("err_busy", 32'(cas_busy), 0);
    tick();
    check("err_clear", 32'(cas_err), 0);
    check("err_busy2", 32'(cas_busy), 0);
    check("err_e7", rd_data_a, model[7]);

    // Reset while in WRITE aborts the operation.
    do_write(0, 32'd5);
    do_write(1, 32'd3);
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd1;
    cas_start = 1'b1;
    cas_addr  = 3'd0;
    tick();
    cas_start = 1'b0;
    tick();
    check("abort_busy_write", 32'(cas_busy), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    check("abort_busy", 32'(cas_busy), 0);
    check("abort_done", 32'(cas_done), 0);
    check("abort_e0", rd_data_a, 0);
    check("abort_e1", rd_data_b, 0);
    tick();
    check("abort_done2", 32'(cas_done), 0);

    // Bubble sort of a reversed fill.
    for (int i = 0; i < 8; i++) do_write(i, 32'(7 - i));
    for (int p = 0; p < 8; p++) begin
      final_pass = (p == 7);
      for (int a = 0; a < 7; a++) do_cas(a, 1'b0, 0, 1'b0);
    end
    final_pass = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      check("sorted", rd_data_a, 32'(i));
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
